alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational ALU (8-bit operands, 16-bit result, `opcodes_t` opcodes from the `definitions` package) among NUM_REQ requesters.
- Arbitration is round-robin. The block captures the winner's operands and drives them onto the ALU for a per-opcode number of cycles, then registers the result.
- The result is returned on a single valid/ready response channel tagged with the requester ID.
- Sits between the instruction/issue logic and the ALU instance; the ALU itself stays outside this block.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATASIZE, 8, operand width.
- OUTPUTSIZE, 2*DATASIZE, result width.
- MULDIV_CYCLES, 3, EXEC cycles for MUL and DIV (>=1).
- ID_W, $clog2(NUM_REQ), requester ID width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant/accept strobe.
- req_in1  in  NUM_REQ*DATASIZE  packed operand 1; requester i occupies slice [i*DATASIZE +: DATASIZE].
- req_in2  in  NUM_REQ*DATASIZE  packed operand 2, same slicing.
- req_opcode  in  NUM_REQ*$bits(opcodes_t)  packed opcodes, same slicing.
- alu_in1  out  DATASIZE  to ALU in1.
- alu_in2  out  DATASIZE  to ALU in2.
- alu_opcode  out  opcodes_t  to ALU opcode.
- alu_result  in  OUTPUTSIZE  from ALU result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  OUTPUTSIZE  registered ALU result.
- rsp_id  out  ID_W  index of the requester that owns rsp_data.
- rsp_err  out  1  DIV with in2==0, or opcode outside ADD..XOR.
- busy  out  1  high in EXEC or RESP.

Behaviour:
- **Reset** (rst high at a clk edge): state=IDLE, rr_ptr=0; all operand registers are 0.
  - Outputs after reset: req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, busy=0.
  - alu_in1/alu_in2=0, alu_opcode=ADD.
  - rst overrides everything, including mid-EXEC or mid-RESP. An in-flight operation is dropped with no response.
- **FSM states:** IDLE, EXEC, RESP.
- **IDLE:**
  - Grant = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready is combinational, one-hot at the grant, and asserted only in IDLE. It is 0 when no req_valid is set.
  - On a grant: capture in1/in2/opcode/ID into registers; load cnt = (opcode is MUL or DIV) ? MULDIV_CYCLES-1 : 0; go to EXEC.
- **EXEC:**
  - alu_* are driven from the captured registers and held stable for the whole of EXEC.
  - cnt>0: decrement cnt.
  - cnt==0:
    - rsp_data <= alu_result; rsp_id <= captured ID.
    - rsp_err <= (DIV && in2==0) || illegal opcode.
    - If rsp_err, rsp_data <= 0.
    - Go to RESP.
- **RESP:**
  - rsp_valid=1; rsp_data, rsp_id and rsp_err are held stable until rsp_ready=1.
  - On rsp_ready: go to IDLE and set rr_ptr <= (captured ID + 1) mod NUM_REQ.
  - No new grant in the same cycle. The next grant occurs in the following IDLE cycle.
- **Outside EXEC:** alu_* hold their last values; they are don't-care to consumers.
- **Latency:** request accepted at cycle 0 -> rsp_valid first high at cycle L+1.
  - L=1 for ADD, SUB, SL, SR, AND, OR, NOT, XOR.
  - L=MULDIV_CYCLES for MUL and DIV.
- **Throughput:** one operation outstanding. Back-to-back minimum interval is L+2 cycles with rsp_ready tied high.
- **Requester rules:**
  - A requester holds req_valid and its operands until it sees req_ready. The block samples operands only in the grant cycle.
  - req_valid dropping without a grant is legal; no request is recorded.
- **Fairness:** a continuously requesting requester is granted within NUM_REQ grants.

Test Plan:
1. Reset, single ADD: rst for 2 cycles; then req 0 sends ADD 8'hFF+8'h01 -> req_ready[0] at cycle 0; rsp_valid at cycle 2 with rsp_data=16'h0100, rsp_id=0, rsp_err=0.
2. MUL latency: req 2 sends MUL 8'd200*8'd3 with MULDIV_CYCLES=3 -> rsp_valid at cycle 4, rsp_data=16'd600, rsp_id=2; alu_in1/alu_in2 stable for cycles 1..3.
3. Round-robin: all 4 req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; no requester granted twice before all others.
4. Divide by zero and backpressure: req 1 sends DIV 8'd7/8'd0 -> rsp_err=1, rsp_data=0. Hold rsp_ready=0 for 5 cycles -> rsp_* unchanged; req_ready stays 0 despite pending req_valid.
5. Reset mid-EXEC: assert rst during a DIV's second EXEC cycle -> next cycle state IDLE, rsp_valid=0, busy=0, rr_ptr=0; the dropped request yields no response.
6. NOT and shift: req 3 sends NOT 8'h00 -> rsp_data=16'h0001; then SL 8'h80 -> rsp_data=16'h0100. Each has rsp_id=3 and L=1.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one external ALU among NUM_REQ requesters.
// One operation in flight; results return on a single id-tagged valid/ready channel.
package definitions;
    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB,
        MUL,
        DIV,
        SL,
        SR,
        AND,
        OR,
        NOT,
        XOR
    } opcodes_t;
endpackage

module alu_arbiter
    import definitions::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATASIZE      = 8,
    parameter int OUTPUTSIZE    = 2*DATASIZE,
    parameter int MULDIV_CYCLES = 3,
    parameter int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ*DATASIZE-1:0]          req_in1,
    input  logic [NUM_REQ*DATASIZE-1:0]          req_in2,
    input  logic [NUM_REQ*$bits(opcodes_t)-1:0]  req_opcode,
    output logic [DATASIZE-1:0]                  alu_in1,
    output logic [DATASIZE-1:0]                  alu_in2,
    output opcodes_t                             alu_opcode,
    input  logic [OUTPUTSIZE-1:0]                alu_result,
    output logic                                 rsp_valid,
    input  logic                                 rsp_ready,
    output logic [OUTPUTSIZE-1:0]                rsp_data,
    output logic [ID_W-1:0]                      rsp_id,
    output logic                                 rsp_err,
    output logic                                 busy
);

    localparam int OPW   = $bits(opcodes_t);
    localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_MD  = CNT_W'(MULDIV_CYCLES - 1);
    localparam logic [ID_W:0]    NREQ    = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [ID_W-1:0]     rr_ptr;
    logic [DATASIZE-1:0] in1_q;
    logic [DATASIZE-1:0] in2_q;
    opcodes_t            op_q;
    logic [ID_W-1:0]     id_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [DATASIZE-1:0] in1_a [NUM_REQ];
    logic [DATASIZE-1:0] in2_a [NUM_REQ];
    opcodes_t            op_a  [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign in1_a[i] = req_in1[i*DATASIZE +: DATASIZE];
        assign in2_a[i] = req_in2[i*DATASIZE +: DATASIZE];
        assign op_a[i]  = opcodes_t'(req_opcode[i*OPW +: OPW]);
    end

    // Rotating priority scan starting at rr_ptr.
    logic            found;
    logic [ID_W-1:0] grant_id;
    logic [ID_W:0]   idx;

    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_valid[idx[ID_W-1:0]]) begin
                found    = 1'b1;
                grant_id = idx[ID_W-1:0];
            end
        end
    end

    logic is_md;
    logic bad_op;
    logic div0;
    logic err_d;

    assign is_md  = (op_a[grant_id] == MUL) || (op_a[grant_id] == DIV);
    assign bad_op = (op_q > XOR);
    assign div0   = (op_q == DIV) && (in2_q == '0);

    always_comb begin
        err_d = 1'b0;
        unique case (1'b1)
            div0:    err_d = 1'b1;
            bad_op:  err_d = 1'b1;
            default: err_d = 1'b0;
        endcase
    end

    logic do_grant;
    logic do_done;
    logic do_accept;

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        do_grant  = 1'b0;
        do_done   = 1'b0;
        do_accept = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready[grant_id] = 1'b1;
                    do_grant            = 1'b1;
                    state_d             = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    do_done = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    do_accept = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            in1_q  <= '0;
            in2_q  <= '0;
            op_q   <= ADD;
            id_q   <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_grant) begin
                in1_q <= in1_a[grant_id];
                in2_q <= in2_a[grant_id];
                op_q  <= op_a[grant_id];
                id_q  <= grant_id;
                cnt_q <= is_md ? CNT_MD : '0;
            end else if (state_q == EXEC && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (do_accept) begin
                rr_ptr <= (id_q == LAST_ID) ? '0 : id_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data <= '0;
            rsp_id   <= '0;
            rsp_err  <= 1'b0;
        end else if (do_done) begin
            rsp_id   <= id_q;
            rsp_err  <= err_d;
            rsp_data <= err_d ? '0 : alu_result;
        end
    end

    assign alu_in1    = in1_q;
    assign alu_in2    = in2_q;
    assign alu_opcode = op_q;
    assign rsp_valid  = (state_q == RESP);
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scoreboard bench for alu_arbiter with a behavioural ALU model.
// Stimulus pushes expected responses; a monitor pops them on each handshake.
module tb_alu_arbiter;
    import definitions::*;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int OW  = 16;
    localparam int IW  = 2;
    localparam int OPW = $bits(opcodes_t);

    logic                clk;
    logic                rst;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N*DW-1:0]     req_in1;
    logic [N*DW-1:0]     req_in2;
    logic [N*OPW-1:0]    req_opcode;
    logic [DW-1:0]       alu_in1;
    logic [DW-1:0]       alu_in2;
    opcodes_t            alu_opcode;
    logic [OW-1:0]       alu_result;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [OW-1:0]       rsp_data;
    logic [IW-1:0]       rsp_id;
    logic                rsp_err;
    logic                busy;

    alu_arbiter #(
        .NUM_REQ(N),
        .DATASIZE(DW),
        .OUTPUTSIZE(OW),
        .MULDIV_CYCLES(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_in1(req_in1),
        .req_in2(req_in2),
        .req_opcode(req_opcode),
        .alu_in1(alu_in1),
        .alu_in2(alu_in2),
        .alu_opcode(alu_opcode),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_id(rsp_id),
        .rsp_err(rsp_err),
        .busy(busy)
    );

    always_comb begin
        alu_result = '0;
        case (alu_opcode)
            ADD: alu_result = {8'h00, alu_in1} + {8'h00, alu_in2};
            SUB: alu_result = {8'h00, alu_in1} - {8'h00, alu_in2};
            MUL: alu_result = {8'h00, alu_in1} * {8'h00, alu_in2};
            DIV: alu_result = (alu_in2 != 0) ? {8'h00, alu_in1 / alu_in2} : 16'hFFFF;
            SL:  alu_result = {8'h00, alu_in1} << 1;
            SR:  alu_result = {8'h00, alu_in1} >> 1;
            AND: alu_result = {8'h00, alu_in1 & alu_in2};
            OR:  alu_result = {8'h00, alu_in1 | alu_in2};
            NOT: alu_result = {15'h0, (alu_in1 == 8'h00)};
            XOR: alu_result = {8'h00, alu_in1 ^ alu_in2};
            default: alu_result = 16'hDEAD;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [OW-1:0] d;
        logic [IW-1:0] id;
        logic          err;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [OW-1:0] d, input int id, input logic err);
        exp_t x;
        x.d   = d;
        x.id  = IW'(id);
        x.err = err;
        sbq.push_back(x);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Monitor samples after stimulus has settled, well before the next rising edge.
    always begin
        @(negedge clk);
        #3;
        if (!rst && rsp_valid && rsp_ready) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rsp_unexpected: got id %0d data %0h expected none", rsp_id, rsp_data);
            end else begin
                e = sbq.pop_front();
                chk("rsp_data", 32'(rsp_data), 32'(e.d));
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    task automatic drive(input int id, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        req_valid[id]            = 1'b1;
        req_in1[id*DW +: DW]     = a;
        req_in2[id*DW +: DW]     = b;
        req_opcode[id*OPW +: OPW] = op;
    endtask

    // Called in cycle 1 after a grant; returns once rsp_valid is seen.
    task automatic wait_rsp(input int lat, input logic [7:0] a, input logic [7:0] b);
        int c;
        c = 1;
        while (!rsp_valid && c < 30) begin
            chk("alu_in1_hold", 32'(alu_in1), 32'(a));
            chk("alu_in2_hold", 32'(alu_in2), 32'(b));
            step();
            c++;
        end
        chk("latency", 32'(c), 32'(lat + 1));
    endtask

    task automatic do_op(input int id, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] d, input logic err,
                         input int lat);
        step();
        drive(id, op, a, b);
        #1;
        chk("grant", 32'(req_ready), 32'(1) << id);
        push(d, id, err);
        step();
        req_valid[id] = 1'b0;
        wait_rsp(lat, a, b);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int w;
        rst        = 1'b1;
        req_valid  = '0;
        req_in1    = '0;
        req_in2    = '0;
        req_opcode = '0;
        rsp_ready  = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_alu_in1", 32'(alu_in1), 0);
        chk("rst_alu_in2", 32'(alu_in2), 0);
        chk("rst_alu_op", 32'(alu_opcode), 32'(ADD));

        do_op(0, ADD, 8'hFF, 8'h01, 16'h0100, 1'b0, 1);
        do_op(2, MUL, 8'd200, 8'd3, 16'd600, 1'b0, 3);
        do_op(3, NOT, 8'h00, 8'h00, 16'h0001, 1'b0, 1);
        do_op(3, SL, 8'h80, 8'h00, 16'h0100, 1'b0, 1);
        do_op(0, SUB, 8'h05, 8'h07, 16'hFFFE, 1'b0, 1);
        do_op(1, XOR, 8'hF0, 8'h3C, 16'h00CC, 1'b0, 1);
        do_op(0, 4'hC, 8'h12, 8'h34, 16'h0000, 1'b1, 1);

        // Round robin from a fresh pointer.
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            drive(i, ADD, 8'(i*16 + 5), 8'h01);
        end
        #1;
        for (int g = 0; g < 5; g++) begin
            w = 0;
            while (req_ready == '0 && w < 20) begin
                step();
                w++;
            end
            chk("rr_grant", 32'(req_ready), 32'(1) << (g % N));
            push(16'((g % N)*16 + 6), g % N, 1'b0);
            step();
        end
        req_valid = '0;
        w = 0;
        while (sbq.size() != 0 && w < 50) begin
            step();
            w++;
        end
        chk("rr_drain", 32'(sbq.size()), 0);

        // Divide by zero under backpressure with another request pending.
        step();
        rsp_ready = 1'b0;
        drive(1, DIV, 8'd7, 8'd0);
        #1;
        chk("bp_grant", 32'(req_ready), 32'h2);
        push(16'h0000, 1, 1'b1);
        step();
        req_valid[1] = 1'b0;
        drive(2, ADD, 8'd3, 8'd4);
        wait_rsp(3, 8'd7, 8'd0);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(rsp_valid), 1);
            chk("bp_data", 32'(rsp_data), 0);
            chk("bp_id", 32'(rsp_id), 1);
            chk("bp_err", 32'(rsp_err), 1);
            chk("bp_no_grant", 32'(req_ready), 0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_next_grant", 32'(req_ready), 32'h4);
        push(16'd7, 2, 1'b0);
        step();
        req_valid[2] = 1'b0;
        wait_rsp(1, 8'd3, 8'd4);

        // Reset in the second EXEC cycle of a DIV drops it.
        step();
        drive(1, DIV, 8'd9, 8'd3);
        #1;
        chk("rx_grant", 32'(req_ready), 32'h2);
        step();
        req_valid[1] = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rx_busy", 32'(busy), 0);
        chk("rx_valid", 32'(rsp_valid), 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rx_no_rsp", 32'(rsp_valid), 0);
        end
        drive(2, OR, 8'h0F, 8'h30);
        drive(0, AND, 8'hF3, 8'h3F);
        #1;
        chk("rx_ptr_zero", 32'(req_ready), 32'h1);
        push(16'h0033, 0, 1'b0);
        step();
        req_valid[0] = 1'b0;
        wait_rsp(1, 8'hF3, 8'h3F);
        step();
        chk("rx_next", 32'(req_ready), 32'h4);
        push(16'h003F, 2, 1'b0);
        step();
        req_valid[2] = 1'b0;
        wait_rsp(1, 8'h0F, 8'h30);

        step();
        step();
        chk("sb_empty", 32'(sbq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
